// File: rtl/add_pkg.sv
// add_pkg: shared definitions for the segment-pipelined adder.
//   addMode_e      operation select carried on in_mode and down the pipeline
//   DEFAULT_WIDTH  default operand/result width
//   DEFAULT_SEG    default bits resolved per pipeline stage
package add_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ADD3 = 2'b10,
    MODE_RSV  = 2'b11
  } addMode_e;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_SEG   = 32;

endpackage

// File: rtl/add_pipe_if.sv
// add_pipe_if: operand/result handshake bundle for add_pipe.
//   in_valid/in_ready    operand-side handshake
//   in_mode              operation select (add_pkg::addMode_e encoding)
//   in_op1..in_op3       operands, in_op3 only meaningful for ADD3
//   out_valid/out_ready  result-side handshake
//   out_sum              result modulo 2^WIDTH
//   out_carry            carry-out (ADD), not-borrow (SUB), 0 (ADD3)
//   out_ovf              signed overflow (ADD/SUB), 0 (ADD3)
// master: operand source and result consumer side. slave: the adder.
interface add_pipe_if
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;
  logic [WIDTH-1:0] in_op3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;

  modport master (
    output in_valid, in_mode, in_op1, in_op2, in_op3, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf
  );

  modport slave (
    input  in_valid, in_mode, in_op1, in_op2, in_op3, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf
  );

endinterface

// File: rtl/add_seg.sv
// add_seg: one SEG-bit carry segment of the pipelined adder.
//   a_i, b_i  segment operands
//   cin_i     carry into the segment
//   s_o       segment sum
//   cout_o    carry out of the segment
module add_seg #(
  parameter int SEG = 32
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] s_o,
  output logic           cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};

endmodule

// File: rtl/add_pipe.sv
// add_pipe: segment-pipelined integer adder (ADD, SUB, three-operand ADD3)
// with a valid/ready handshake and a global stall.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    add_pipe_if.slave: operands in, result out
// Stage k resolves carry segment k; results leave STAGES cycles after the
// operand set is accepted.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG   = DEFAULT_SEG
) (
  input  logic       clk,
  input  logic       rst_n,
  add_pipe_if.slave  bus
);

  localparam int STAGES = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : gGeomCheck
    $error("add_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             stall;
  logic             lastValid;
  logic [WIDTH-1:0] condA;
  logic [WIDTH-1:0] condB;
  logic             condCin;

  // The whole pipeline freezes while a finished result waits for the consumer.
  assign stall        = lastValid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Operand conditioning: SUB becomes A + ~B + 1; ADD3 is folded to two
  // operands by a carry-save stage (sum bits + majority shifted up one).
  always_comb begin
    condA   = bus.in_op1;
    condB   = bus.in_op2;
    condCin = 1'b0;
    case (bus.in_mode)
      MODE_SUB: begin
        condB   = ~bus.in_op2;
        condCin = 1'b1;
      end
      MODE_ADD3: begin
        condA = bus.in_op1 ^ bus.in_op2 ^ bus.in_op3;
        condB = ((bus.in_op1 & bus.in_op2) |
                 (bus.in_op1 & bus.in_op3) |
                 (bus.in_op2 & bus.in_op3)) << 1;
      end
      default: begin
      end
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : gStage
    // Operand bits not yet consumed by earlier stages, LSB-aligned.
    localparam int REM = WIDTH - k * SEG;

    logic                  inValid;
    logic [1:0]            inMode;
    logic                  inCin;
    logic [REM-1:0]        inA;
    logic [REM-1:0]        inB;
    logic [SEG-1:0]        segSum;
    logic                  segCout;
    logic [(k+1)*SEG-1:0]  sum_d;
    logic [(k+1)*SEG-1:0]  sum_q;
    logic                  valid_q;
    logic [1:0]            mode_q;
    logic                  carry_q;

    if (k == 0) begin : gHead
      assign inValid = bus.in_valid;
      assign inMode  = bus.in_mode;
      assign inCin   = condCin;
      assign inA     = condA;
      assign inB     = condB;
      assign sum_d   = segSum;
    end else begin : gBody
      assign inValid = gStage[k-1].valid_q;
      assign inMode  = gStage[k-1].mode_q;
      assign inCin   = gStage[k-1].carry_q;
      assign inA     = gStage[k-1].gPass.remA_q;
      assign inB     = gStage[k-1].gPass.remB_q;
      assign sum_d   = {segSum, gStage[k-1].sum_q};
    end

    add_seg #(
      .SEG (SEG)
    ) uSeg (
      .a_i    (inA[SEG-1:0]),
      .b_i    (inB[SEG-1:0]),
      .cin_i  (inCin),
      .s_o    (segSum),
      .cout_o (segCout)
    );

    // Bubbles advance like real entries; their data fields are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        mode_q  <= MODE_ADD;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (!stall) begin
        valid_q <= inValid;
        mode_q  <= inMode;
        carry_q <= segCout;
        sum_q   <= sum_d;
      end
    end

    if (k < STAGES - 1) begin : gPass
      logic [REM-SEG-1:0] remA_q;
      logic [REM-SEG-1:0] remB_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          remA_q <= '0;
          remB_q <= '0;
        end else if (!stall) begin
          remA_q <= inA[REM-1:SEG];
          remB_q <= inB[REM-1:SEG];
        end
      end
    end else begin : gLast
      logic ovf_d;
      logic ovf_q;

      // Only the top segment sees the operand sign bits, so overflow is
      // decided here from the conditioned operands.
      assign ovf_d = (inMode != MODE_ADD3) &&
                     (inA[REM-1] == inB[REM-1]) &&
                     (segSum[SEG-1] != inA[REM-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign lastValid     = gStage[STAGES-1].valid_q;
  assign bus.out_valid = lastValid;
  assign bus.out_sum   = gStage[STAGES-1].sum_q;
  assign bus.out_carry = gStage[STAGES-1].carry_q &&
                         (gStage[STAGES-1].mode_q != MODE_ADD3);
  assign bus.out_ovf   = gStage[STAGES-1].gLast.ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: scoreboard bench for add_pipe in the 64/32 geometry and the
// 16/4 geometry. Expected results are computed by an arithmetic model when
// an operand set is accepted and compared when the result is delivered.
module tb_add_pipe;
  import add_pkg::*;

  localparam int STAGES64 = 2;
  localparam int STAGES16 = 4;

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    int          acceptCycle;
    bit          checkLat;
  } expItem_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   checkCount;
  int   failCount;

  expItem_t sb64[$];
  expItem_t sb16[$];

  bit          lat64Seen;
  bit          lat16Seen;
  bit          stalledPrev;
  logic [63:0] prevSum;
  logic        prevCarry;
  logic        prevOvf;

  add_pipe_if #(.WIDTH(64)) bus64 ();
  add_pipe_if #(.WIDTH(16)) bus16 ();

  add_pipe #(.WIDTH(64), .SEG(32)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  add_pipe #(.WIDTH(16), .SEG(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index; read only at falling edges.
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic for a w-bit adder, from the operation definitions.
  function automatic expItem_t modelResult(input int w, input logic [1:0] mode,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
    expItem_t    r;
    logic [63:0] mask;
    logic [64:0] full;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a & mask;
    b = b & mask;
    c = c & mask;
    r.acceptCycle = 0;
    r.checkLat = 1'b0;
    case (mode)
      MODE_SUB: begin
        r.sum   = (a - b) & mask;
        r.carry = (a >= b);
        r.ovf   = (a[w-1] != b[w-1]) && (r.sum[w-1] != a[w-1]);
      end
      MODE_ADD3: begin
        r.sum   = (a + b + c) & mask;
        r.carry = 1'b0;
        r.ovf   = 1'b0;
      end
      default: begin
        full    = {1'b0, a} + {1'b0, b};
        r.sum   = full[63:0] & mask;
        r.carry = full[w];
        r.ovf   = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
      end
    endcase
    return r;
  endfunction

  // Present one operand set (called just after a rising edge), hold it until
  // accepted, and push the expected result at the accepting cycle.
  task automatic applyStimulus(input bit narrow, input logic [1:0] mode,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] c, input bit checkLat);
    expItem_t it;
    bit       accepted;
    it = modelResult(narrow ? 16 : 64, mode, a, b, c);
    it.checkLat = checkLat;
    if (narrow) begin
      bus16.in_valid = 1'b1;
      bus16.in_mode  = mode;
      bus16.in_op1   = a[15:0];
      bus16.in_op2   = b[15:0];
      bus16.in_op3   = c[15:0];
    end else begin
      bus64.in_valid = 1'b1;
      bus64.in_mode  = mode;
      bus64.in_op1   = a;
      bus64.in_op2   = b;
      bus64.in_op3   = c;
    end
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (rst_n && (narrow ? bus16.in_ready : bus64.in_ready)) begin
        accepted = 1'b1;
        it.acceptCycle = cycle;
        if (narrow) sb16.push_back(it);
        else        sb64.push_back(it);
      end
      @(posedge clk);
      #1;
    end
    if (narrow) bus16.in_valid = 1'b0;
    else        bus64.in_valid = 1'b0;
    checkOutput("accept", accepted, 1'b1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && (sb64.size() + sb16.size()) != 0; i++) begin
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput("drain", sb64.size() + sb16.size(), 0);
  endtask

  // Result monitor, 64-bit instance: handshake relation, values, latency,
  // and hold-stability while stalled.
  always @(negedge clk) begin
    expItem_t e;
    if (rst_n) begin
      checkOutput("inReadyVsStall", bus64.in_ready, !(bus64.out_valid && !bus64.out_ready));
      if (bus64.out_valid) begin
        if (sb64.size() == 0) begin
          checkOutput("spurious64", bus64.out_valid, 1'b0);
        end else begin
          e = sb64[0];
          if (!lat64Seen && e.checkLat)
            checkOutput("latency64", cycle - e.acceptCycle, STAGES64);
          lat64Seen = 1'b1;
          checkOutput("sum64", bus64.out_sum, e.sum);
          checkOutput("carry64", bus64.out_carry, e.carry);
          checkOutput("ovf64", bus64.out_ovf, e.ovf);
          if (stalledPrev) begin
            checkOutput("holdSum", bus64.out_sum, prevSum);
            checkOutput("holdCarry", bus64.out_carry, prevCarry);
            checkOutput("holdOvf", bus64.out_ovf, prevOvf);
          end
          if (bus64.out_ready) begin
            void'(sb64.pop_front());
            lat64Seen = 1'b0;
          end
        end
      end
      stalledPrev = bus64.out_valid && !bus64.out_ready;
      prevSum     = bus64.out_sum;
      prevCarry   = bus64.out_carry;
      prevOvf     = bus64.out_ovf;
    end else begin
      stalledPrev = 1'b0;
      lat64Seen   = 1'b0;
    end
  end

  // Result monitor, 16-bit instance (consumer always ready).
  always @(negedge clk) begin
    expItem_t e;
    if (rst_n) begin
      if (bus16.out_valid) begin
        if (sb16.size() == 0) begin
          checkOutput("spurious16", bus16.out_valid, 1'b0);
        end else begin
          e = sb16[0];
          if (!lat16Seen && e.checkLat)
            checkOutput("latency16", cycle - e.acceptCycle, STAGES16);
          lat16Seen = 1'b1;
          checkOutput("sum16", bus16.out_sum, e.sum);
          checkOutput("carry16", bus16.out_carry, e.carry);
          checkOutput("ovf16", bus16.out_ovf, e.ovf);
          if (bus16.out_ready) begin
            void'(sb16.pop_front());
            lat16Seen = 1'b0;
          end
        end
      end
    end else begin
      lat16Seen = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] allOnes;
    allOnes    = '1;
    checkCount = 0;
    failCount  = 0;
    cycle      = 0;
    rst_n      = 1'b0;
    bus64.in_valid = 1'b0; bus64.in_mode = MODE_ADD; bus64.out_ready = 1'b1;
    bus64.in_op1 = '0; bus64.in_op2 = '0; bus64.in_op3 = '0;
    bus16.in_valid = 1'b0; bus16.in_mode = MODE_ADD; bus16.out_ready = 1'b1;
    bus16.in_op1 = '0; bus16.in_op2 = '0; bus16.in_op3 = '0;
    #1;
    checkOutput("rstValid64", bus64.out_valid, 1'b0);
    checkOutput("rstReady64", bus64.in_ready, 1'b1);
    checkOutput("rstSum64", bus64.out_sum, 64'd0);
    checkOutput("rstCarry64", bus64.out_carry, 1'b0);
    checkOutput("rstOvf64", bus64.out_ovf, 1'b0);
    checkOutput("rstValid16", bus16.out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations, 64/32");
    applyStimulus(0, MODE_ADD,  64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 1);
    applyStimulus(0, MODE_SUB,  64'd5, 64'd7, 64'd0, 1);
    applyStimulus(0, MODE_SUB,  64'd7, 64'd5, 64'd0, 1);
    applyStimulus(0, MODE_SUB,  64'h8000_0000_0000_0000, 64'd1, 64'd0, 1);
    applyStimulus(0, MODE_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
    applyStimulus(0, MODE_ADD,  allOnes, 64'd1, 64'd0, 1);
    applyStimulus(0, MODE_ADD3, 64'd1, 64'd2, 64'd3, 1);
    applyStimulus(0, MODE_ADD3, allOnes, allOnes, allOnes, 1);
    applyStimulus(0, MODE_RSV,  64'd10, 64'd20, 64'd99, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 2'($urandom_range(3)), {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom}, 1);
    end
    waitDrain();

    $display("[TB] back-to-back with backpressure");
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(0, MODE_ADD, 64'(i), 64'(100 * i), 64'd0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus64.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus64.out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] reset with operations in flight");
    bus64.out_ready = 1'b0;
    applyStimulus(0, MODE_ADD, 64'd11, 64'd22, 64'd0, 0);
    applyStimulus(0, MODE_SUB, 64'd50, 64'd8, 64'd0, 0);
    rst_n = 1'b0;
    #1;
    sb64.delete();
    checkOutput("midRstValid", bus64.out_valid, 1'b0);
    checkOutput("midRstReady", bus64.in_ready, 1'b1);
    checkOutput("midRstSum", bus64.out_sum, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus64.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(0, MODE_ADD, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'd0, 1);
    waitDrain();

    $display("[TB] alternate geometry 16/4");
    applyStimulus(1, MODE_ADD, 64'h00FF, 64'd1, 64'd0, 1);
    applyStimulus(1, MODE_ADD, 64'hFFFF, 64'd1, 64'd0, 1);
    applyStimulus(1, MODE_SUB, 64'h8000, 64'd1, 64'd0, 1);
    applyStimulus(1, MODE_ADD3, 64'h0FFF, 64'h0F0F, 64'h00F0, 1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, segment-pipelined integer adder with valid/ready handshake and three operating modes: two-operand add, subtract, and three-operand add through a carry-save front end. It generalises the fixed 64-bit lookahead-carry and carry-save adders to any width. The carry chain is split into SEG-bit segments, one per pipeline stage, so wide adds close timing at full clock rate. It sits between operand sources (ALU/MAC datapaths) and result consumers that may apply backpressure.

## Interface
- WIDTH, 64: operand/result width in bits; must be a multiple of SEG, otherwise elaboration fails.
- SEG, 32: bits resolved per pipeline stage; STAGES = WIDTH/SEG.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  block can accept this cycle.
- in_mode  in  2  operation select: ADD, SUB, ADD3, or reserved.
- in_op1 / in_op2 / in_op3  in  WIDTH each  operands; in_op3 is used only in ADD3.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_carry  out  1  carry-out (ADD), not-borrow (SUB), 0 (ADD3).
- out_ovf  out  1  signed overflow (ADD/SUB), 0 (ADD3).

## Operation
- Acceptance: in_valid && in_ready. Delivery: out_valid && out_ready.
- Input conditioning is combinational, ahead of stage 0.
  - ADD: A=op1, B=op2, cin=0.
  - SUB: A=op1, B=~op2, cin=1.
  - ADD3: A=op1^op2^op3, B=maj(op1,op2,op3)<<1 (MSB dropped), cin=0.
  - Reserved mode behaves as ADD.
- Stage k (0..STAGES-1) register holds:
  - valid bit and mode;
  - resolved sum bits [(k+1)*SEG-1:0];
  - unresolved A/B upper bits;
  - segment carry.
- Stage k resolves segment k as A_seg + B_seg + carry_in, where carry_in is cin for k=0 and the stage k-1 carry otherwise.
- Output = last stage register. out_carry = final segment carry (ADD/SUB).
- out_ovf = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]), where A/B are the conditioned operands (ADD/SUB only).
- Global stall: stall = out_valid && !out_ready. While stalled, no stage register changes.
  - in_ready = !stall, computed combinationally and independent of in_valid.
- Bubbles (invalid stages) advance normally; data fields of invalid stages are don't-care.

## Timing
- Latency: an operand set accepted at edge t produces out_valid at edge t+STAGES, absent stalls.
- Throughput: one result per cycle when out_ready stays high.
- Reset, asynchronous on rst_n low: all stage valid bits clear, so out_valid=0 and in_ready=1. out_sum, out_carry and out_ovf are 0. Data registers also clear to 0.
- Reset mid-flight discards every in-flight operation. No partial result appears after release.
- Simultaneous delivery and acceptance in the same cycle is legal and loses nothing.
- out_sum/carry/ovf hold stable while out_valid && !out_ready.
- STAGES=1 degenerates to a single registered adder with latency 1.

## Structure
- Shared package add_pkg:
  - mode constants MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ADD3=2'b10, MODE_RSV=2'b11;
  - default WIDTH/SEG localparams.
- Sub-module add_seg: SEG-bit ripple/lookahead adder (a, b, cin -> s, cout). Instantiated once per stage in a generate loop.
- The CSA/invert front end stays inline in add_pipe.

## Test plan
- Carry across the segment boundary (WIDTH=64, SEG=32): ADD 0x0000_0000_FFFF_FFFF + 1 -> out_sum 0x0000_0001_0000_0000, carry 0, ovf 0, out_valid exactly 2 cycles after acceptance.
- Subtract:
  - SUB 5-7 -> 0xFFFF_FFFF_FFFF_FFFE, carry 0, ovf 0.
  - SUB 7-5 -> 2, carry 1.
  - SUB 0x8000_0000_0000_0000 - 1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf 1.
- Overflow and wrap:
  - ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> 0x8000_0000_0000_0000, ovf 1.
  - ADD all-ones + 1 -> 0, carry 1.
- ADD3:
  - 1, 2, 3 -> 6.
  - all-ones ×3 -> 0xFFFF_FFFF_FFFF_FFFD, carry 0, ovf 0.
- Backpressure: 6 back-to-back ADDs (i + 100*i), out_ready low for 3 cycles mid-stream.
  - in_ready falls the same cycle stall asserts.
  - All 6 results are delivered in order, with no duplicates or loss.
  - Outputs are stable while stalled.
- Reset and alternate geometry:
  - Assert rst_n low with 2 ops in flight -> out_valid 0 immediately and neither op is ever delivered. The next op after release is correct.
  - Repeat the first scenario with WIDTH=16, SEG=4: 0x00FF + 1 -> 0x0100, latency 4.
